// File: rtl/serial_link_pkg.sv
// Framing definitions shared by the serial word transmitter and receiver so
// both ends of the link agree on word width and state encoding.
package serial_link_pkg;

    localparam int DEF_WIDTH = 10;

    typedef logic [DEF_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered head word, so the
// read data is a flop output that always reflects the current head entry.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic [AW:0]      wr_ptr_nxt;

    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_en};
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_en};
    assign empty      = (rd_ptr == wr_ptr);
    assign full       = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // The head after this edge is either the word being written into an
    // otherwise-empty queue, or an entry already in memory; hold when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
                rdata <= wdata;
            end else if (rd_ptr_nxt != wr_ptr) begin
                rdata <= mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Deserializes LSB-first frames framed by an active-low strobe into words,
// flags short/long frames and queues good words behind a valid/ready FIFO.
module serial_word_rx
    import serial_link_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [1:0]       state_o
);

    localparam int         CW       = $clog2(WIDTH + 1);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    // Handshake: word_o is transferred on a rising edge where valid_o && ready_i;
    // valid_o never depends on ready_i and stays up until the transfer happens.

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic             fresh;
    logic             push_q;
    logic [WIDTH-1:0] push_word;
    logic             err_det;
    logic             full;
    logic             empty;
    logic             pop;
    logic             accept;

    assign valid_o = ~empty;
    assign pop     = valid_o & ready_i;
    assign accept  = push_q & (~full | pop);
    assign state_o = state;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .wr_en (accept),
        .wdata (push_word),
        .rd_en (pop),
        .rdata (word_o),
        .full  (full),
        .empty (empty)
    );

    // fresh marks the first edge after reset: a strobe already low then belongs
    // to a frame whose head was lost, so it is flushed rather than shifted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            count       <= '0;
            sreg        <= '0;
            fresh       <= 1'b1;
            push_q      <= 1'b0;
            push_word   <= '0;
            err_det     <= 1'b0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            fresh       <= 1'b0;
            push_q      <= 1'b0;
            err_det     <= 1'b0;
            frame_err_o <= err_det;
            overflow_o  <= push_q & full & ~pop;
            if (accept) begin
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (!ena_i) begin
                        if (fresh) begin
                            state <= ST_FLUSH;
                        end else begin
                            sreg[0] <= data_i;
                            count   <= CW'(1);
                            state   <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!ena_i) begin
                        if (count < CW'(WIDTH)) begin
                            sreg[count] <= data_i;
                            count       <= count + CW'(1);
                        end else begin
                            err_det <= 1'b1;
                            count   <= '0;
                            state   <= ST_FLUSH;
                        end
                    end else begin
                        if (count == CW'(WIDTH)) begin
                            push_q    <= 1'b1;
                            push_word <= sreg;
                        end else begin
                            err_det <= 1'b1;
                        end
                        count <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (ena_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: framing, errors, backpressure, reset
// behaviour and the full-FIFO simultaneous push/pop case.
module tb_serial_word_rx;

    localparam int W  = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b1;
    logic          data = 1'b0;
    logic          ready = 1'b1;
    logic [W-1:0]  word;
    logic          valid;
    logic          frame_err;
    logic          overflow;
    logic [CW-1:0] frame_cnt;
    logic [1:0]    state;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int pop_cnt = 0;
    logic [W-1:0] exp_q[$];

    serial_word_rx #(
        .WIDTH      (W),
        .FIFO_DEPTH (4),
        .CNT_W      (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ena_i       (ena),
        .data_i      (data),
        .word_o      (word),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (frame_err),
        .overflow_o  (overflow),
        .frame_cnt_o (frame_cnt),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Transfers are scored just before the edge that performs them; pulses are
    // counted just after each edge.
    task automatic tick();
        logic [W-1:0] e;
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(word), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_word", 32'(word), 32'(e));
            end
            pop_cnt++;
        end
        @(posedge clk);
        #1;
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
    endtask

    task automatic send_frame(input logic [W-1:0] value, input int len);
        for (int i = 0; i < len; i++) begin
            ena  = 1'b0;
            data = (i < W) ? value[i] : 1'($urandom_range(0, 1));
            tick();
        end
        ena  = 1'b1;
        data = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b1;
        #1;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        err_cnt = 0;
        ovf_cnt = 0;
        pop_cnt = 0;
    endtask

    initial begin
        // Single frame and reset values
        ready = 1'b1;
        do_reset();
        check("rst_word", 32'(word), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        exp_q.push_back(10'd6);
        send_frame(10'd6, W);
        check("single_valid_e1", 32'(valid), 0);
        tick();
        check("single_valid_e2", 32'(valid), 1);
        check("single_word", 32'(word), 6);
        check("single_cnt", 32'(frame_cnt), 1);
        tick();
        check("single_valid_e3", 32'(valid), 0);
        check("single_q_empty", 32'(exp_q.size()), 0);

        // Burst of 100 back-to-back frames
        do_reset();
        for (int n = 0; n < 100; n++) begin
            exp_q.push_back(10'd6);
            send_frame(10'd6, W);
        end
        repeat (3) tick();
        check("burst_cnt", 32'(frame_cnt), 100);
        check("burst_pops", 32'(pop_cnt), 100);
        check("burst_err", 32'(err_cnt), 0);
        check("burst_ovf", 32'(ovf_cnt), 0);
        check("burst_q_empty", 32'(exp_q.size()), 0);

        // Short frame then long frame then a good frame
        do_reset();
        send_frame(10'h3FF, 7);
        check("short_err_e1", 32'(frame_err), 0);
        tick();
        check("short_err_e2", 32'(frame_err), 1);
        tick();
        check("short_err_e3", 32'(frame_err), 0);
        check("short_err_cnt", 32'(err_cnt), 1);
        check("short_valid", 32'(valid), 0);
        send_frame(10'h155, 13);
        repeat (2) tick();
        check("long_err_cnt", 32'(err_cnt), 2);
        check("long_valid", 32'(valid), 0);
        check("long_cnt", 32'(frame_cnt), 0);
        exp_q.push_back(10'h2AA);
        send_frame(10'h2AA, W);
        repeat (3) tick();
        check("after_err_cnt", 32'(frame_cnt), 1);
        check("after_err_q", 32'(exp_q.size()), 0);
        check("after_err_errs", 32'(err_cnt), 2);

        // Backpressure with overflow on the fifth frame
        do_reset();
        ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n <= 4) exp_q.push_back(W'(n));
            send_frame(W'(n), W);
        end
        repeat (2) tick();
        check("bp_ovf", 32'(ovf_cnt), 1);
        check("bp_cnt", 32'(frame_cnt), 4);
        check("bp_valid", 32'(valid), 1);
        check("bp_head", 32'(word), 1);
        ready = 1'b1;
        repeat (6) tick();
        check("bp_pops", 32'(pop_cnt), 4);
        check("bp_q_empty", 32'(exp_q.size()), 0);
        check("bp_valid_end", 32'(valid), 0);

        // Reset in the middle of a frame, strobe still low on release
        do_reset();
        ready = 1'b0;
        send_frame(10'h0F0, W);
        tick();
        check("mid_pre_valid", 32'(valid), 1);
        for (int i = 0; i < 5; i++) begin
            ena  = 1'b0;
            data = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        check("mid_rst_word", 32'(word), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_cnt", 32'(frame_cnt), 0);
        check("mid_rst_err", 32'(frame_err), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        err_cnt = 0;
        ovf_cnt = 0;
        repeat (5) tick();
        ena = 1'b1;
        repeat (3) tick();
        check("mid_flush_err", 32'(err_cnt), 0);
        check("mid_flush_cnt", 32'(frame_cnt), 0);
        check("mid_flush_valid", 32'(valid), 0);
        ready = 1'b1;
        exp_q.push_back(10'h155);
        send_frame(10'h155, W);
        repeat (3) tick();
        check("mid_next_cnt", 32'(frame_cnt), 1);
        check("mid_next_q", 32'(exp_q.size()), 0);

        // Full FIFO with push and pop on the same edge
        do_reset();
        ready = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            exp_q.push_back(W'(n * 10));
            send_frame(W'(n * 10), W);
        end
        exp_q.push_back(10'd50);
        send_frame(10'd50, W);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("full_pp_ovf", 32'(ovf_cnt), 0);
        check("full_pp_cnt", 32'(frame_cnt), 5);
        check("full_pp_valid", 32'(valid), 1);
        check("full_pp_head", 32'(word), 20);
        send_frame(10'd60, W);
        tick();
        check("full_still_ovf", 32'(ovf_cnt), 1);
        check("full_still_cnt", 32'(frame_cnt), 5);
        ready = 1'b1;
        repeat (6) tick();
        check("full_pops", 32'(pop_cnt), 5);
        check("full_q_empty", 32'(exp_q.size()), 0);
        check("full_valid_end", 32'(valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Receive-side counterpart of the serial word transmitter: deserializes LSB-first frames delimited by an active-low `ena` strobe (one bit per clock, `WIDTH` bits per frame) back into parallel words. Completed words go through a small output FIFO with a valid/ready handshake. Malformed frames are flagged and discarded. The block sits at the sink end of the serial link, clocked on the same `clk_i` as the transmitter.

## Interface
- `WIDTH`, 10: bits per frame.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the good-frame counter.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ena_i`  in  1  frame strobe; low = frame in progress, high = idle.
- `data_i`  in  1  serial data; bit *k* is valid in the *k*-th cycle `ena_i` is low (k=0 first, LSB first).
- `word_o`  out  WIDTH  FIFO head word.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  consumer accepts `word_o` when `valid_o && ready_i` at a rising edge.
- `frame_err_o`  out  1  one-cycle pulse on a short or long frame.
- `overflow_o`  out  1  one-cycle pulse when a good word is dropped because the FIFO is full.
- `frame_cnt_o`  out  CNT_W  count of words written into the FIFO; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, SHIFT, FLUSH.
- **IDLE**
  - `ena_i`=0: capture `data_i` into shift-register bit 0, set bit counter to 1, go to SHIFT.
  - `ena_i`=1: stay in IDLE.
- **SHIFT**
  - `ena_i`=0 and count<WIDTH: store `data_i` at index `count`, then increment count.
  - `ena_i`=1 and count==WIDTH: frame good. Push the word, return to IDLE.
  - `ena_i`=1 and count<WIDTH: short frame. Pulse `frame_err_o`, discard, return to IDLE.
  - `ena_i`=0 and count==WIDTH: long frame. Pulse `frame_err_o`, discard, go to FLUSH.
- **FLUSH**
  - Ignore `data_i` until `ena_i`=1, then go to IDLE.
  - Only one error pulse is raised per long frame.
- **Push, FIFO not full:** write the word and increment `frame_cnt_o`.
- **Push, FIFO full:**
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise pulse `overflow_o`, drop the word, and leave `frame_cnt_o` unchanged.
- **Back-to-back frames:** a single idle cycle (`ena_i`=1) between frames is sufficient. This is the cycle in which the push happens.
- **Reset:**
  - Outputs: `word_o`=0, `valid_o`=0, `frame_err_o`=0, `overflow_o`=0, `frame_cnt_o`=0.
  - FSM goes to IDLE, FIFO is emptied, bit counter is cleared.
  - Reset asserted mid-frame aborts the frame with no error pulse. If `ena_i` is still low when reset releases, the block enters FLUSH (not SHIFT), so a partial frame is never accepted.

## Timing
- Frame end is detected on the first rising edge where `ena_i`=1 after `WIDTH` low cycles.
- `valid_o` rises on the next edge. Latency from the last data bit to `valid_o`=1 is 2 cycles.
- `frame_err_o` asserts on the edge after the violation is detected and lasts exactly 1 cycle.
- `word_o` is registered and always equals the FIFO head. When `valid_o`=0 its value is undefined, but it is 0 after reset.
- Simultaneous push and pop on an empty FIFO: `valid_o` goes high the next cycle.
- Throughput: one word per `WIDTH+1` cycles, sustained with `ready_i`=1.

## Structure
- Package `serial_link_pkg`:
  - `WIDTH` default constant.
  - `word_t` typedef (`logic [WIDTH-1:0]`).
  - Enum `rx_state_e` {IDLE, SHIFT, FLUSH}.
  - Shared with the transmitter so both ends agree on framing.
- Sub-module `sync_fifo`, parameterized by width and depth:
  - Pointers one bit wider than the address, for full/empty.
  - Outputs: `full`, `empty`, `rdata`.
- The top level holds the FSM, the shift register, the bit counter, the error/overflow pulse registers and `frame_cnt_o`.

## Test plan
- **Single frame:** reset 4 cycles, then send 0b0000000110 (6) LSB-first with `ready_i`=1 → `word_o`=6, `valid_o` high 1 cycle, 2 cycles after the last bit; `frame_cnt_o`=1.
- **Burst:** 100 back-to-back frames of 6 with 1 idle cycle between them and `ready_i`=1 → 100 words of 6, no `frame_err_o`, `frame_cnt_o`=100.
- **Short/long frames:**
  - `ena_i` low for 7 cycles → one `frame_err_o` pulse, no push.
  - `ena_i` low for 13 cycles → one pulse, no push.
  - The next good frame of 0x2AA is then received correctly.
- **Backpressure:** `ready_i`=0 with 5 good frames (1..5) sent → 4 words held, one `overflow_o` pulse on frame 5, `frame_cnt_o`=4. Then raise `ready_i` → pops return 1, 2, 3, 4 in order.
- **Reset mid-frame:**
  - Assert `rst_i` after 5 bits while `ena_i` stays low → all outputs 0.
  - The rest of the frame is ignored via FLUSH; no error pulse and no push.
  - The next full frame is received correctly.
- **Full-FIFO edge case:** FIFO full, then push and pop in the same cycle → push accepted, no `overflow_o`, FIFO stays full.
